decoder_bmp: RTL

//  Parses a 24-bit uncompressed BMP byte stream (the file format encoder_bmp emits) and outputs raw pixel bytes.

---
 rtl/decoder_bmp.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/decoder_bmp.sv
// Parses a 24-bit uncompressed BMP byte stream and emits pixel bytes in file order.
// Pixel path latency 1 cycle through a 1-entry output register; source stalls while that register is full and not taken.
module decoder_bmp #(
  parameter logic [15:0] MAX_WIDTH  = 16'd1024,
  parameter logic [15:0] MAX_HEIGHT = 16'd1024
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_i,
  input  logic        decoder_start_i,
  output logic        decoder_ready_o,
  output logic        decoder_done_o,
  output logic        decoder_err_o,
  output logic [2:0]  decoder_err_code_o,
  input  logic [7:0]  bmp_data_i,
  input  logic        bmp_data_valid_i,
  output logic        bmp_data_ready_o,
  output logic [15:0] img_width_o,
  output logic [15:0] img_height_o,
  output logic [7:0]  pix_data_o,
  output logic        pix_data_valid_o,
  input  logic        pix_data_ready_i,
  output logic        pix_eol_o,
  output logic        pix_last_o
);

  typedef enum logic [2:0] {IDLE, HEADER, SKIP, PIXEL, PAD, DONE, ERROR} state_t;

  state_t      state;
  logic [5:0]  hdr_cnt;
  logic [31:0] off_r, wid_r, hgt_r;
  logic [15:0] bpp_r;
  logic [17:0] col_cnt;
  logic [15:0] row_cnt;
  logic [15:0] skip_cnt;
  logic [1:0]  pad_cnt;

  logic        accept;
  logic [1:0]  lane;
  logic [17:0] row_bytes;
  logic        row_end, last_row, size_ok, off_ok;

  assign decoder_ready_o = (state == IDLE) || (state == ERROR);
  assign img_width_o     = wid_r[15:0];
  assign img_height_o    = hgt_r[15:0];

  always_comb begin
    bmp_data_ready_o = 1'b0;
    case (state)
      HEADER, SKIP, PAD, ERROR: bmp_data_ready_o = 1'b1;
      PIXEL:                    bmp_data_ready_o = !pix_data_valid_o || pix_data_ready_i;
      default:                  bmp_data_ready_o = 1'b0;
    endcase
  end

  assign accept    = bmp_data_valid_i && bmp_data_ready_o;
  // Every little-endian field starts at a byte index with [1:0]==2 except bpp.
  assign lane      = hdr_cnt[1:0] - 2'd2;
  assign row_bytes = {2'b00, wid_r[15:0]} + {1'b0, wid_r[15:0], 1'b0};
  assign row_end   = (col_cnt == row_bytes - 18'd1);
  assign last_row  = (row_cnt == hgt_r[15:0] - 16'd1);
  assign size_ok   = (wid_r[31:16] == 16'd0) && (hgt_r[31:16] == 16'd0) &&
                     (wid_r[15:0] != 16'd0) && (hgt_r[15:0] != 16'd0) &&
                     (wid_r[15:0] <= MAX_WIDTH) && (hgt_r[15:0] <= MAX_HEIGHT);
  assign off_ok    = (off_r[31:16] == 16'd0) && (off_r[15:0] >= 16'd54);

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state              <= IDLE;
      hdr_cnt            <= '0;
      off_r              <= '0;
      wid_r              <= '0;
      hgt_r              <= '0;
      bpp_r              <= '0;
      col_cnt            <= '0;
      row_cnt            <= '0;
      skip_cnt           <= '0;
      pad_cnt            <= '0;
      decoder_done_o     <= 1'b0;
      decoder_err_o      <= 1'b0;
      decoder_err_code_o <= '0;
      pix_data_o         <= '0;
      pix_data_valid_o   <= 1'b0;
      pix_eol_o          <= 1'b0;
      pix_last_o         <= 1'b0;
    end else begin
      decoder_done_o <= 1'b0;
      if (pix_data_valid_o && pix_data_ready_i) begin
        pix_data_valid_o <= 1'b0;
        pix_eol_o        <= 1'b0;
        pix_last_o       <= 1'b0;
      end
      case (state)
        IDLE, ERROR: begin
          if (state == ERROR) begin
            pix_data_valid_o <= 1'b0;
            pix_eol_o        <= 1'b0;
            pix_last_o       <= 1'b0;
          end
          if (decoder_start_i) begin
            state              <= HEADER;
            hdr_cnt            <= '0;
            decoder_err_o      <= 1'b0;
            decoder_err_code_o <= '0;
            off_r              <= '0;
            wid_r              <= '0;
            hgt_r              <= '0;
            bpp_r              <= '0;
            col_cnt            <= '0;
            row_cnt            <= '0;
          end
        end
        HEADER: if (accept) begin
          hdr_cnt <= hdr_cnt + 6'd1;
          if (hdr_cnt >= 6'd10 && hdr_cnt <= 6'd13) off_r[{lane, 3'b000} +: 8] <= bmp_data_i;
          if (hdr_cnt >= 6'd18 && hdr_cnt <= 6'd21) wid_r[{lane, 3'b000} +: 8] <= bmp_data_i;
          if (hdr_cnt >= 6'd22 && hdr_cnt <= 6'd25) hgt_r[{lane, 3'b000} +: 8] <= bmp_data_i;
          if (hdr_cnt == 6'd28) bpp_r[7:0]  <= bmp_data_i;
          if (hdr_cnt == 6'd29) bpp_r[15:8] <= bmp_data_i;
          if ((hdr_cnt == 6'd0 && bmp_data_i != 8'h42) || (hdr_cnt == 6'd1 && bmp_data_i != 8'h4D)) begin
            state <= ERROR; decoder_err_o <= 1'b1; decoder_err_code_o <= 3'd1;
          end else if (hdr_cnt == 6'd53) begin
            if (bpp_r != 16'd24) begin
              state <= ERROR; decoder_err_o <= 1'b1; decoder_err_code_o <= 3'd2;
            end else if (!size_ok) begin
              state <= ERROR; decoder_err_o <= 1'b1; decoder_err_code_o <= 3'd3;
            end else if (!off_ok) begin
              state <= ERROR; decoder_err_o <= 1'b1; decoder_err_code_o <= 3'd4;
            end else begin
              state    <= (off_r[15:0] > 16'd54) ? SKIP : PIXEL;
              skip_cnt <= off_r[15:0] - 16'd54;
            end
          end
        end
        SKIP: if (accept) begin
          skip_cnt <= skip_cnt - 16'd1;
          if (skip_cnt == 16'd1) state <= PIXEL;
        end
        PIXEL: if (accept) begin
          pix_data_o       <= bmp_data_i;
          pix_data_valid_o <= 1'b1;
          pix_eol_o        <= row_end;
          pix_last_o       <= row_end && last_row;
          if (row_end) begin
            col_cnt <= '0;
            row_cnt <= row_cnt + 16'd1;
            if (wid_r[1:0] != 2'd0) begin
              state   <= PAD;
              pad_cnt <= wid_r[1:0];
            end else if (last_row) begin
              state <= DONE;
            end
          end else begin
            col_cnt <= col_cnt + 18'd1;
          end
        end
        // row_cnt was already advanced at the row end, so it equals height after the last row.
        PAD: if (accept) begin
          pad_cnt <= pad_cnt - 2'd1;
          if (pad_cnt == 2'd1) state <= (row_cnt == hgt_r[15:0]) ? DONE : PIXEL;
        end
        DONE: if (!pix_data_valid_o) begin
          decoder_done_o <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
